// File: rtl/queue_seq_ctrl.sv
// Pointer and sequencing controller for a circular sample queue on a
// 1-cycle-read-latency dual-port RAM: fills FILL samples, then bursts a sliding window per write.
module queue_seq_ctrl #(
  parameter int DEPTH = 1024,
  parameter int FILL  = 1021,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrt_smpl,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          sequencing,
  output logic          smpl_vld,
  output logic          full,
  output logic          dropped
);

  typedef enum logic [1:0] {
    S_FILLING = 2'd0,
    S_IDLE    = 2'd1,
    S_SEQ     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d;
  logic [AW-1:0] old_ptr_q, old_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] bcnt_q, bcnt_d;
  logic          full_q, full_d;
  logic          seq_q;
  logic          vld_q;
  logic          drop_q;
  logic          accept_s;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  assign accept_s   = (state_q != S_SEQ);
  assign ram_we     = wrt_smpl & accept_s;
  assign ram_waddr  = new_ptr_q;
  assign ram_raddr  = rd_ptr_q;
  assign ram_re     = seq_q;
  assign sequencing = seq_q;
  assign smpl_vld   = vld_q;
  assign full       = full_q;
  assign dropped    = drop_q;

  // Next-state, pointer and burst-counter logic.
  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    old_ptr_d = old_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    full_d    = full_q;
    case (state_q)
      S_FILLING: begin
        if (wrt_smpl) begin
          new_ptr_d = ptr_inc(new_ptr_q);
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == AW'(FILL - 1)) begin
            full_d   = 1'b1;
            state_d  = S_SEQ;
            rd_ptr_d = old_ptr_q;
            bcnt_d   = '0;
          end else begin
            state_d  = S_FILLING;
          end
        end else begin
          state_d = S_FILLING;
        end
      end
      S_IDLE: begin
        if (wrt_smpl) begin
          new_ptr_d = ptr_inc(new_ptr_q);
          old_ptr_d = ptr_inc(old_ptr_q);
          rd_ptr_d  = ptr_inc(old_ptr_q);
          bcnt_d    = '0;
          state_d   = S_SEQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEQ: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        bcnt_d   = bcnt_q + AW'(1);
        if (bcnt_q == AW'(FILL - 1)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEQ;
        end
      end
      default: begin
        state_d = S_FILLING;
      end
    endcase
  end

  // State, pointer and registered output flops; rst aborts any burst at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILLING;
      new_ptr_q <= '0;
      old_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      full_q    <= 1'b0;
      seq_q     <= 1'b0;
      vld_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_ptr_q <= new_ptr_d;
      old_ptr_q <= old_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      full_q    <= full_d;
      seq_q     <= (state_d == S_SEQ);
      vld_q     <= seq_q;
      drop_q    <= wrt_smpl & ~accept_s;
    end
  end

endmodule

// File: tb/tb_queue_seq_ctrl.sv
// Randomized bench for queue_seq_ctrl: emulates the external RAM and checks
// every cycle against a sample-count/burst-window model of the queue.
module tb_queue_seq_ctrl;
  localparam int DEPTH = 1024;
  localparam int FILL  = 1021;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrt_smpl = 1'b0;
  logic          ram_we, ram_re, sequencing, smpl_vld, full, dropped;
  logic [AW-1:0] ram_waddr, ram_raddr;

  int vectors = 0;
  int errors  = 0;

  queue_seq_ctrl #(.DEPTH(DEPTH), .FILL(FILL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wrt_smpl(wrt_smpl),
    .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_re(ram_re), .ram_raddr(ram_raddr),
    .sequencing(sequencing), .smpl_vld(smpl_vld),
    .full(full), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // External RAM: written data is the running sample number.
  int mem [DEPTH];
  int wcount = 0;
  int rdata  = 0;
  always @(posedge clk) begin
    if (rst) wcount <= 0;
    else if (ram_we) begin
      mem[ram_waddr] <= wcount;
      wcount <= wcount + 1;
    end
    if (ram_re) rdata <= mem[ram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: nsamp accepted samples; burst occupies cycles bstart..bend and
  // reads samples bfirst.. in order; sample n lives at address n mod DEPTH.
  int  c = 0, nsamp = 0, bstart = -10, bend = -10, bfirst = 0;
  bit  drop_prev = 1'b0, started = 1'b0;

  always @(negedge clk) begin
    bit in_seq, vld_exp;
    in_seq  = (c >= bstart) && (c <= bend);
    vld_exp = (c - 1 >= bstart) && (c - 1 <= bend);
    if (started) begin
      chk("sequencing", 32'(sequencing), 32'(in_seq));
      chk("ram_re", 32'(ram_re), 32'(in_seq));
      chk("ram_we", 32'(ram_we), 32'(wrt_smpl & ~in_seq));
      chk("ram_waddr", 32'(ram_waddr), 32'(nsamp % DEPTH));
      chk("full", 32'(full), 32'(nsamp >= FILL));
      chk("dropped", 32'(dropped), 32'(drop_prev));
      chk("smpl_vld", 32'(smpl_vld), 32'(vld_exp));
      if (in_seq) chk("ram_raddr", 32'(ram_raddr), 32'((bfirst + c - bstart) % DEPTH));
      if (vld_exp) chk("rdata", 32'(rdata), 32'(bfirst + c - 1 - bstart));
    end
    if (rst) begin
      nsamp = 0; bstart = -10; bend = -10; drop_prev = 1'b0; started = 1'b1;
    end else begin
      drop_prev = wrt_smpl && in_seq;
      if (wrt_smpl && !in_seq) begin
        nsamp++;
        if (nsamp >= FILL) begin
          bstart = c + 1; bend = c + FILL; bfirst = nsamp - FILL;
        end
      end
    end
    c++;
  end

  task automatic cycle(input bit w, input bit r);
    @(posedge clk);
    #1;
    wrt_smpl = w;
    rst = r;
  endtask

  // Call just after a negedge; returns at the negedge where sequencing is low.
  task automatic wait_idle(input bit noise);
    int n = 0;
    while (sequencing === 1'b1 && n < 3 * FILL) begin
      cycle((noise && n < FILL - 8) ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b0);
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FILL) chk("burst_timeout", 32'(sequencing), 32'd0);
  endtask

  task automatic write_one(input int exp_addr);
    cycle(1'b1, 1'b0);
    @(negedge clk);
    chk("lit_we", 32'(ram_we), 32'd1);
    chk("lit_waddr", 32'(ram_waddr), 32'(exp_addr));
    cycle(1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int run;
    bit seen_low;
    rst = 1'b1;
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_rst_full", 32'(full), 32'd0);
    chk("lit_rst_seq", 32'(sequencing), 32'd0);
    chk("lit_rst_waddr", 32'(ram_waddr), 32'd0);

    // Fill to FILL-1, then the filling write launches the first burst.
    repeat (FILL - 1) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_prefill_full", 32'(full), 32'd0);
    chk("lit_prefill_seq", 32'(sequencing), 32'd0);
    write_one(1020);
    chk("lit_full", 32'(full), 32'd1);
    chk("lit_first_raddr", 32'(ram_raddr), 32'd0);
    wait_idle(1'b1);

    // Sliding writes up to the wrap of the write pointer.
    write_one(1021);
    chk("lit_raddr_1022", 32'(ram_raddr), 32'd1);
    wait_idle(1'b1);
    write_one(1022);
    wait_idle(1'b0);
    write_one(1023);
    wait_idle(1'b0);
    write_one(0);
    chk("lit_raddr_wrap", 32'(ram_raddr), 32'd4);
    wait_idle(1'b1);

    // Explicit drop mid-burst, then reset around burst cycle 500.
    write_one(1);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    @(negedge clk);
    chk("lit_drop_we", 32'(ram_we), 32'd0);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_dropped", 32'(dropped), 32'd1);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_dropped_once", 32'(dropped), 32'd0);
    repeat (476) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_abort_seq", 32'(sequencing), 32'd0);
    chk("lit_abort_full", 32'(full), 32'd0);
    chk("lit_abort_waddr", 32'(ram_waddr), 32'd0);

    // Refill with random gaps: no burst before FILL writes.
    for (int k = 0; k < FILL - 1; ) begin
      bit w;
      w = ($urandom_range(0, 1) == 1);
      cycle(w, 1'b0);
      if (w) k++;
    end
    cycle(1'b0, 1'b0);
    @(negedge clk);
    chk("lit_refill_seq", 32'(sequencing), 32'd0);
    chk("lit_refill_full", 32'(full), 32'd0);
    repeat (3000) cycle($urandom_range(0, 3) == 0, 1'b0);

    // Write strobe tied high: FILL cycles of sequencing, one idle cycle.
    run = 0;
    seen_low = 1'b0;
    for (int k = 0; k < 3 * (FILL + 1) + 10; k++) begin
      cycle(1'b1, 1'b0);
      @(negedge clk);
      if (sequencing === 1'b1) run++;
      else begin
        if (seen_low && run > 0) chk("lit_run_len", 32'(run), 32'(FILL));
        seen_low = 1'b1;
        run = 0;
      end
    end
    cycle(1'b0, 1'b0);
    @(negedge clk);
    wait_idle(1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
